regfile_sb: RTL

//  Parametrised register file with per-register scoreboard for the pipelined core.
//  - Provides NREAD combinational read ports and one write port, with write-to-read bypass.
//  - Tracks registers that have an in-flight producer. It raises RAW stalls and blocks WAW issue.
//  - Sits between decode (reads, issue) and writeback (write, busy clear).

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_rdport.sv | 49 ++++
 rtl/regfile_sb.sv | 84 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, types and helpers for the scoreboarded register file
package regfile_pkg;

    localparam int XZR_IDX = 31;

    // Source chosen by a read port for its data output
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_BYP  = 2'd1,
        SEL_ARR  = 2'd2
    } rd_sel_t;

    function automatic int regfile_aw(int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one combinational read port: decode, bypass/zero select and RAW stall
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = 64,
    parameter  int DEPTH    = 32,
    parameter  int ZERO_REG = XZR_IDX,
    localparam int AW       = regfile_aw(DEPTH)
) (
    input  logic [AW-1:0]                ra,
    input  logic                         we,
    input  logic [AW-1:0]                wa,
    input  logic [WIDTH-1:0]             wd,
    input  logic [DEPTH-1:0][WIDTH-1:0]  regs,
    input  logic [DEPTH-1:0]             busy,
    output logic [WIDTH-1:0]             rd,
    output logic                         raw_stall
);

    logic    in_range;
    logic    is_zero;
    logic    wb_hit;
    rd_sel_t sel;

    always_comb begin
        in_range = (32'(ra) < DEPTH);
        is_zero  = (ra == AW'(ZERO_REG));
        wb_hit   = we && (wa == ra);

        // Zero/out-of-range wins so the hardwired register never sees bypassed data
        if (is_zero || !in_range) begin
            sel = SEL_ZERO;
        end else if (wb_hit) begin
            sel = SEL_BYP;
        end else begin
            sel = SEL_ARR;
        end

        unique case (sel)
            SEL_ZERO: rd = '0;
            SEL_BYP:  rd = wd;
            SEL_ARR:  rd = regs[ra];
            default:  rd = '0;
        endcase

        raw_stall = in_range && !is_zero && busy[ra] && !wb_hit;
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with write bypass and per-register in-flight producer scoreboard
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = 64,
    parameter  int DEPTH    = 32,
    parameter  int NREAD    = 2,
    parameter  int ZERO_REG = XZR_IDX,
    parameter  int INIT_IDX = 1,
    localparam int AW       = regfile_aw(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*AW-1:0]     ra,
    output logic [NREAD*WIDTH-1:0]  rd,
    output logic [NREAD-1:0]        raw_stall,
    input  logic                    we,
    input  logic [AW-1:0]           wa,
    input  logic [WIDTH-1:0]        wd,
    input  logic                    iss_valid,
    input  logic [AW-1:0]           iss_wa,
    output logic                    iss_ready,
    output logic [AW:0]             busy_cnt
);

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            busy;
    logic [DEPTH-1:0]            busy_next;
    logic                        wr_ok;
    logic                        iss_ok;
    logic                        iss_busy;
    logic                        issue_fire;

    always_comb begin
        wr_ok      = we && (wa != AW'(ZERO_REG)) && (32'(wa) < DEPTH);
        iss_ok     = (iss_wa != AW'(ZERO_REG)) && (32'(iss_wa) < DEPTH);
        iss_busy   = iss_ok && busy[iss_wa];
        // A same-cycle writeback to the destination retires the old producer
        iss_ready  = !iss_busy || (we && (wa == iss_wa));
        issue_fire = iss_valid && iss_ready && iss_ok;

        busy_next = busy;
        if (wr_ok) begin
            busy_next[wa] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[iss_wa] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (INIT_IDX != 0 && i != ZERO_REG) ? WIDTH'(i) : '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_ok) begin
                regs[wa] <= wd;
            end
            busy     <= busy_next;
            busy_cnt <= (AW+1)'($countones(busy_next));
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        regfile_rdport #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .ra        (ra[k*AW +: AW]),
            .we        (we),
            .wa        (wa),
            .wd        (wd),
            .regs      (regs),
            .busy      (busy),
            .rd        (rd[k*WIDTH +: WIDTH]),
            .raw_stall (raw_stall[k])
        );
    end

endmodule
